// File: rtl/crypto_job_sequencer_pkg.sv
// Shared definitions for the crypto job sequencer: opcodes, FSM states and default sizing.
// The host-side command decoder uses the same opcode values.
package crypto_job_sequencer_pkg;

  localparam int DATA_W_DEFAULT         = 128;
  localparam int TIMEOUT_CYCLES_DEFAULT = 50_000_000;

  typedef enum logic [1:0] {
    OP_ECHO = 2'b00,
    OP_ENC  = 2'b01,
    OP_RT   = 2'b10,
    OP_BAD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENC_RUN   = 3'd1,
    ST_LINK_SEND = 3'd2,
    ST_LINK_WAIT = 3'd3,
    ST_ECHO_RUN  = 3'd4,
    ST_RESPOND   = 3'd5
  } state_e;

endpackage

// File: rtl/crypto_job_sequencer_if.sv
// Bundle of the host command, engine and host transmitter signals around the sequencer.
// master is the sequencer side; slave is the host/engine side.
interface crypto_job_sequencer_if
  import crypto_job_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              enc_start;
  logic [DATA_W-1:0] enc_msg;
  logic              enc_done;
  logic [DATA_W-1:0] enc_result;
  logic              link_tx_wr;
  logic [DATA_W-1:0] link_tx_data;
  logic              link_received;
  logic [DATA_W-1:0] link_rx_data;
  logic              echo_start;
  logic              echo_done;
  logic [DATA_W-1:0] echo_result;
  logic [DATA_W-1:0] tx_data;
  logic              tx_wr;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, enc_done, enc_result,
           link_received, link_rx_data, echo_done, echo_result,
    output cmd_ready, enc_start, enc_msg, link_tx_wr, link_tx_data,
           echo_start, tx_data, tx_wr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, enc_done, enc_result,
           link_received, link_rx_data, echo_done, echo_result,
    input  cmd_ready, enc_start, enc_msg, link_tx_wr, link_tx_data,
           echo_start, tx_data, tx_wr
  );

endinterface

// File: rtl/crypto_job_sequencer_rise_detect.sv
// Rising-edge detector against a registered history bit.
// RESET_VAL=1 suppresses a false edge when the input is already high out of reset.
module rise_detect #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clock) begin
    if (reset) prev <= RESET_VAL;
    else       prev <= in;
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/crypto_job_sequencer.sv
// Runs one host job at a time on the encoder, link transceiver or echo unit and returns
// one result word per job, flagging engine timeouts and illegal opcodes.
module crypto_job_sequencer
  import crypto_job_sequencer_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  crypto_job_sequencer_if.master bus,
  output logic                   busy,
  output logic                   err_timeout,
  output logic                   err_badop
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e            state, state_nx;
  op_e               op_q;
  logic [TO_W-1:0]   to_cnt;
  logic              link_rise, enc_hit, echo_hit, expired, in_wait;
  logic              enc_start_q, echo_start_q, link_tx_wr_q, tx_wr_q;
  logic              enc_start_nx, echo_start_nx, link_tx_wr_nx, tx_wr_nx;
  logic [DATA_W-1:0] enc_msg_q, link_tx_data_q, tx_data_q;
  logic [DATA_W-1:0] enc_msg_nx, link_tx_data_nx, tx_data_nx;
  logic              err_timeout_nx, err_badop_nx;

  rise_detect #(.RESET_VAL(1'b1)) u_link_rise (
    .clock (clock),
    .reset (reset),
    .in    (bus.link_received),
    .pulse (link_rise)
  );

  // A done that coincides with its own start pulse belongs to an earlier request.
  assign enc_hit  = bus.enc_done  & ~enc_start_q;
  assign echo_hit = bus.echo_done & ~echo_start_q;
  assign expired  = (to_cnt == TO_LAST);
  assign in_wait  = (state == ST_ENC_RUN) || (state == ST_LINK_WAIT) || (state == ST_ECHO_RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      op_q           <= OP_ECHO;
      to_cnt         <= '0;
      enc_start_q    <= 1'b0;
      echo_start_q   <= 1'b0;
      link_tx_wr_q   <= 1'b0;
      tx_wr_q        <= 1'b0;
      enc_msg_q      <= '0;
      link_tx_data_q <= '0;
      tx_data_q      <= '0;
      err_timeout    <= 1'b0;
      err_badop      <= 1'b0;
    end else begin
      state          <= state_nx;
      if (state == ST_IDLE && bus.cmd_valid) op_q <= op_e'(bus.cmd_op);
      if (state_nx != state)                 to_cnt <= '0;
      else if (in_wait)                      to_cnt <= to_cnt + TO_W'(1);
      enc_start_q    <= enc_start_nx;
      echo_start_q   <= echo_start_nx;
      link_tx_wr_q   <= link_tx_wr_nx;
      tx_wr_q        <= tx_wr_nx;
      enc_msg_q      <= enc_msg_nx;
      link_tx_data_q <= link_tx_data_nx;
      tx_data_q      <= tx_data_nx;
      err_timeout    <= err_timeout_nx;
      err_badop      <= err_badop_nx;
    end
  end

  // A completion arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (op_e'(bus.cmd_op))
            OP_ECHO:        state_nx = ST_ECHO_RUN;
            OP_ENC, OP_RT:  state_nx = ST_ENC_RUN;
            default:        state_nx = ST_IDLE;
          endcase
        end
      end
      ST_ENC_RUN: begin
        if (enc_hit)      state_nx = (op_q == OP_RT) ? ST_LINK_SEND : ST_RESPOND;
        else if (expired) state_nx = ST_IDLE;
      end
      ST_LINK_SEND: state_nx = ST_LINK_WAIT;
      ST_LINK_WAIT: begin
        if (link_rise)    state_nx = ST_RESPOND;
        else if (expired) state_nx = ST_IDLE;
      end
      ST_ECHO_RUN: begin
        if (echo_hit)     state_nx = ST_RESPOND;
        else if (expired) state_nx = ST_IDLE;
      end
      ST_RESPOND: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Strobes are launched on the transition so they appear in the first cycle of the new state.
  always_comb begin
    enc_start_nx    = 1'b0;
    echo_start_nx   = 1'b0;
    link_tx_wr_nx   = 1'b0;
    tx_wr_nx        = 1'b0;
    enc_msg_nx      = enc_msg_q;
    link_tx_data_nx = link_tx_data_q;
    tx_data_nx      = tx_data_q;
    err_timeout_nx  = err_timeout;
    err_badop_nx    = err_badop;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          err_timeout_nx = 1'b0;
          err_badop_nx   = (op_e'(bus.cmd_op) == OP_BAD);
          enc_msg_nx     = bus.cmd_data;
          enc_start_nx   = (state_nx == ST_ENC_RUN);
          echo_start_nx  = (state_nx == ST_ECHO_RUN);
        end
      end
      ST_ENC_RUN: begin
        if (enc_hit) begin
          if (op_q == OP_RT) begin
            link_tx_data_nx = bus.enc_result;
            link_tx_wr_nx   = 1'b1;
          end else begin
            tx_data_nx = bus.enc_result;
            tx_wr_nx   = 1'b1;
          end
        end else if (expired) begin
          err_timeout_nx = 1'b1;
        end
      end
      ST_LINK_WAIT: begin
        if (link_rise) begin
          tx_data_nx = bus.link_rx_data;
          tx_wr_nx   = 1'b1;
        end else if (expired) begin
          err_timeout_nx = 1'b1;
        end
      end
      ST_ECHO_RUN: begin
        if (echo_hit) begin
          tx_data_nx = bus.echo_result;
          tx_wr_nx   = 1'b1;
        end else if (expired) begin
          err_timeout_nx = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready    = (state == ST_IDLE);
  assign busy             = (state != ST_IDLE);
  assign bus.enc_start    = enc_start_q;
  assign bus.echo_start   = echo_start_q;
  assign bus.link_tx_wr   = link_tx_wr_q;
  assign bus.tx_wr        = tx_wr_q;
  assign bus.enc_msg      = enc_msg_q;
  assign bus.link_tx_data = link_tx_data_q;
  assign bus.tx_data      = tx_data_q;

endmodule

// File: tb/tb_crypto_job_sequencer.sv
// Directed bench for crypto_job_sequencer: echo, encrypt-only, round-trip, timeout, bad
// opcode, stray completions and reset mid-job, with hand-computed expectations.
module tb_crypto_job_sequencer;
  import crypto_job_sequencer_pkg::*;

  localparam int DATA_W         = 128;
  localparam int TIMEOUT_CYCLES = 64;

  localparam logic [DATA_W-1:0] ECHO_DATA = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;
  localparam logic [DATA_W-1:0] ECHO_RES  = 128'hFEED_FACE_0000_1111_2222_3333_DEAD_BEEF;
  localparam logic [DATA_W-1:0] CIPHER    = 128'h0A1B;

  logic clock = 1'b0;
  logic reset;
  logic busy, err_timeout, err_badop;

  int total = 0;
  int bad = 0;
  int tx_cnt = 0;
  int link_cnt = 0;
  int start_cnt = 0;
  int dbl_cnt = 0;
  logic [3:0] strobes;
  logic [3:0] prev_strobes = 4'b0;

  crypto_job_sequencer_if #(.DATA_W(DATA_W)) bus ();

  crypto_job_sequencer #(
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_badop   (err_badop)
  );

  always #5 clock = ~clock;

  // Strobe bookkeeping sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    strobes = {bus.tx_wr, bus.link_tx_wr, bus.enc_start, bus.echo_start};
    if (bus.tx_wr) tx_cnt++;
    if (bus.link_tx_wr) link_cnt++;
    if (bus.enc_start || bus.echo_start) start_cnt++;
    if ((strobes & prev_strobes) != 4'b0) dbl_cnt++;
    prev_strobes = strobes;
  end

  task automatic check_output(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [1:0] op, input logic [DATA_W-1:0] d);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(1'b0, OP_ECHO, '0);
    bus.enc_done      = 1'b0;
    bus.enc_result    = '0;
    bus.link_received = 1'b1;
    bus.link_rx_data  = '0;
    bus.echo_done     = 1'b0;
    bus.echo_result   = '0;
    tick(3);
    reset = 1'b0;
    @(negedge clock);
    check_output("reset_ctl", {bus.cmd_ready, busy, err_timeout, err_badop,
                               bus.tx_wr, bus.enc_start, bus.echo_start, bus.link_tx_wr},
                 8'b1000_0000);
    check_output("reset_tx_data", bus.tx_data, '0);

    // link_received held high through reset must not look like a completion
    tick(5);
    check_output("link_high_reset_tx", tx_cnt, 0);
    bus.link_received = 1'b0;
    tick(2);

    // ECHO job with a stray echo_done on the start-pulse cycle
    apply_stimulus(1'b1, OP_ECHO, ECHO_DATA);
    tick(1);
    apply_stimulus(1'b0, OP_ECHO, '0);
    bus.echo_done   = 1'b1;
    bus.echo_result = 128'hBAD;
    @(negedge clock);
    check_output("echo_start", {bus.echo_start, bus.enc_start, busy, bus.cmd_ready}, 4'b1010);
    check_output("echo_latched", bus.enc_msg, ECHO_DATA);
    tick(1);
    bus.echo_done = 1'b0;
    @(negedge clock);
    check_output("echo_same_cycle_done", bus.tx_wr, 1'b0);
    tick(4);
    bus.echo_done   = 1'b1;
    bus.echo_result = ECHO_RES;
    tick(1);
    bus.echo_done = 1'b0;
    @(negedge clock);
    check_output("echo_tx", {bus.tx_wr, err_timeout, err_badop}, 3'b100);
    check_output("echo_data", bus.tx_data, ECHO_RES);
    tick(1);
    @(negedge clock);
    check_output("echo_after", {bus.tx_wr, busy, bus.cmd_ready}, 3'b001);
    check_output("echo_hold", bus.tx_data, ECHO_RES);

    // ENC_ONLY: enc_done 20 cycles after start
    apply_stimulus(1'b1, OP_ENC, 128'd65);
    tick(1);
    apply_stimulus(1'b0, OP_ECHO, '0);
    @(negedge clock);
    check_output("enc_start", {bus.enc_start, bus.echo_start, busy}, 3'b101);
    check_output("enc_msg", bus.enc_msg, 128'd65);
    tick(20);
    bus.enc_done   = 1'b1;
    bus.enc_result = CIPHER;
    @(negedge clock);
    check_output("enc_done_cycle_tx", bus.tx_wr, 1'b0);
    tick(1);
    bus.enc_done = 1'b0;
    @(negedge clock);
    check_output("enc_tx", {bus.tx_wr, bus.link_tx_wr}, 2'b10);
    check_output("enc_data", bus.tx_data, CIPHER);
    tick(1);
    check_output("enc_counts", {tx_cnt[7:0], link_cnt[7:0]}, 16'h0200);

    // ROUNDTRIP: ciphertext out over the link, reply 40 cycles later
    apply_stimulus(1'b1, OP_RT, 128'd65);
    tick(1);
    apply_stimulus(1'b0, OP_ECHO, '0);
    @(negedge clock);
    check_output("rt_start", bus.enc_start, 1'b1);
    tick(20);
    bus.enc_done   = 1'b1;
    bus.enc_result = CIPHER;
    tick(1);
    bus.enc_done = 1'b0;
    @(negedge clock);
    check_output("rt_link_wr", {bus.link_tx_wr, bus.tx_wr}, 2'b10);
    check_output("rt_link_data", bus.link_tx_data, CIPHER);
    tick(40);
    bus.link_received = 1'b1;
    bus.link_rx_data  = 128'd65;
    @(negedge clock);
    check_output("rt_wait", {busy, bus.tx_wr}, 2'b10);
    tick(1);
    @(negedge clock);
    check_output("rt_tx", bus.tx_wr, 1'b1);
    check_output("rt_data", bus.tx_data, 128'd65);
    tick(1);
    bus.link_received = 1'b0;
    check_output("rt_counts", {tx_cnt[7:0], link_cnt[7:0]}, 16'h0301);

    // TIMEOUT: enc_done withheld for the full budget
    apply_stimulus(1'b1, OP_ENC, 128'h77);
    tick(1);
    apply_stimulus(1'b0, OP_ECHO, '0);
    tick(63);
    @(negedge clock);
    check_output("to_before", {busy, err_timeout}, 2'b10);
    tick(1);
    @(negedge clock);
    check_output("to_expired", {busy, err_timeout, bus.tx_wr, bus.cmd_ready}, 4'b0101);
    tick(1);
    check_output("to_no_tx", tx_cnt, 3);

    // BADOP: flag set, timeout flag cleared, no engine started
    apply_stimulus(1'b1, OP_BAD, 128'h5);
    tick(1);
    apply_stimulus(1'b0, OP_ECHO, '0);
    @(negedge clock);
    check_output("badop_flags", {err_badop, err_timeout, busy, bus.cmd_ready}, 4'b1001);
    tick(3);
    check_output("badop_no_start", start_cnt, 4);

    // Next accepted job clears err_badop
    apply_stimulus(1'b1, OP_ECHO, 128'h1);
    tick(1);
    apply_stimulus(1'b0, OP_ECHO, '0);
    @(negedge clock);
    check_output("badop_cleared", {err_badop, err_timeout, bus.echo_start}, 3'b001);
    tick(1);
    bus.echo_done   = 1'b1;
    bus.echo_result = 128'h2222;
    tick(1);
    bus.echo_done = 1'b0;
    @(negedge clock);
    check_output("echo2_tx", bus.tx_wr, 1'b1);
    check_output("echo2_data", bus.tx_data, 128'h2222);

    // enc_done on the expiry cycle: completion wins
    tick(1);
    apply_stimulus(1'b1, OP_ENC, 128'h99);
    tick(1);
    apply_stimulus(1'b0, OP_ECHO, '0);
    tick(63);
    bus.enc_done   = 1'b1;
    bus.enc_result = 128'h5555;
    tick(1);
    bus.enc_done = 1'b0;
    @(negedge clock);
    check_output("expiry_tie", {bus.tx_wr, err_timeout}, 2'b10);
    check_output("expiry_tie_data", bus.tx_data, 128'h5555);

    // Stray completions while idle
    tick(2);
    bus.enc_done      = 1'b1;
    bus.echo_done     = 1'b1;
    bus.link_received = 1'b1;
    tick(1);
    bus.enc_done  = 1'b0;
    bus.echo_done = 1'b0;
    tick(1);
    bus.link_received = 1'b0;
    tick(4);
    check_output("stray_idle_tx", tx_cnt, 5);
    @(negedge clock);
    check_output("stray_idle_busy", busy, 1'b0);

    // Reset in LINK_WAIT with a job offered and link_received high across reset
    tick(1);
    apply_stimulus(1'b1, OP_RT, 128'h42);
    tick(1);
    apply_stimulus(1'b0, OP_ECHO, '0);
    tick(5);
    bus.enc_done   = 1'b1;
    bus.enc_result = 128'hC1;
    tick(1);
    bus.enc_done = 1'b0;
    tick(10);
    @(negedge clock);
    check_output("rst_pre_busy", busy, 1'b1);
    tick(1);
    reset = 1'b1;
    bus.link_received = 1'b1;
    apply_stimulus(1'b1, OP_ENC, 128'h3);
    tick(1);
    @(negedge clock);
    check_output("rst_abort", {busy, bus.enc_start, bus.tx_wr, bus.cmd_ready}, 4'b0001);
    tick(1);
    reset = 1'b0;
    apply_stimulus(1'b0, OP_ECHO, '0);
    tick(5);
    check_output("rst_no_false_done", {tx_cnt[7:0], start_cnt[7:0]}, 16'h0507);
    bus.link_received = 1'b0;
    tick(1);
    apply_stimulus(1'b1, OP_ECHO, 128'h9);
    tick(1);
    apply_stimulus(1'b0, OP_ECHO, '0);
    @(negedge clock);
    check_output("post_rst_echo_start", bus.echo_start, 1'b1);
    tick(2);
    bus.echo_done   = 1'b1;
    bus.echo_result = 128'h3333;
    tick(1);
    bus.echo_done = 1'b0;
    @(negedge clock);
    check_output("post_rst_echo_tx", bus.tx_wr, 1'b1);
    check_output("post_rst_echo_data", bus.tx_data, 128'h3333);
    tick(2);
    check_output("strobe_double", dbl_cnt, 0);
    check_output("link_total", link_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
